// File: rtl/super_sha256d.sv
// super_sha256d: self-running SHA-256d of "abc", one compression round per clock
module super_sha256d (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] h1,
  output logic [31:0] h2,
  output logic [31:0] h3,
  output logic [31:0] h4,
  output logic [31:0] h5,
  output logic [31:0] h6,
  output logic [31:0] h7,
  output logic [31:0] h8,
  output logic [31:0] h1_2,
  output logic [31:0] h2_2,
  output logic [31:0] h3_2,
  output logic [31:0] h4_2,
  output logic [31:0] h5_2,
  output logic [31:0] h6_2,
  output logic [31:0] h7_2,
  output logic [31:0] h8_2,
  output logic        done
);
  localparam logic [2:0] INIT1 = 3'd0;
  localparam logic [2:0] RND1  = 3'd1;
  localparam logic [2:0] FIN1  = 3'd2;
  localparam logic [2:0] INIT2 = 3'd3;
  localparam logic [2:0] RND2  = 3'd4;
  localparam logic [2:0] FIN2  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;
  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  logic [2:0]  state;
  logic [5:0]  cnt;
  logic [31:0] v [8];
  logic [31:0] w [16];
  logic [31:0] d1 [8];
  logic [31:0] d2 [8];
  logic [31:0] wt, t1, t2;
  logic        blk1;

  // window holds W[t-16..t-1]; during rounds 0-15 its head is the loaded W[t]
  always_comb begin
    blk1 = state == INIT1;
    wt = cnt < 6'd16 ? w[0] : ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[cnt] + wt;
    t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT1;
      cnt   <= '0;
      done  <= 1'b0;
      v     <= '{default: '0};
      w     <= '{default: '0};
      d1    <= '{default: '0};
      d2    <= '{default: '0};
    end else begin
      case (state)
        INIT1, INIT2: begin
          v <= IV;
          for (int i = 0; i < 8; i++) w[i] <= blk1 ? (i == 0 ? 32'h61626380 : 32'h0) : d1[i];
          for (int i = 9; i < 15; i++) w[i] <= '0;
          w[8]  <= blk1 ? 32'h0 : 32'h80000000;
          w[15] <= blk1 ? 32'h00000018 : 32'h00000100;
          cnt   <= '0;
          state <= blk1 ? RND1 : RND2;
        end
        RND1, RND2: begin
          v[0] <= t1 + t2;
          v[1] <= v[0];
          v[2] <= v[1];
          v[3] <= v[2];
          v[4] <= v[3] + t1;
          v[5] <= v[4];
          v[6] <= v[5];
          v[7] <= v[6];
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= wt;
          cnt   <= cnt + 6'd1;
          if (cnt == 6'd63) state <= state == RND1 ? FIN1 : FIN2;
        end
        FIN1: begin
          for (int i = 0; i < 8; i++) d1[i] <= IV[i] + v[i];
          state <= INIT2;
        end
        FIN2: begin
          for (int i = 0; i < 8; i++) d2[i] <= IV[i] + v[i];
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= DONE;
      endcase
    end
  end

  assign {h1, h2, h3, h4, h5, h6, h7, h8} = {d1[0], d1[1], d1[2], d1[3], d1[4], d1[5], d1[6], d1[7]};
  assign {h1_2, h2_2, h3_2, h4_2, h5_2, h6_2, h7_2, h8_2} = {d2[0], d2[1], d2[2], d2[3], d2[4], d2[5], d2[6], d2[7]};
endmodule

// File: tb/tb_super_sha256d.sv
// tb_super_sha256d: directed vectors for the SHA-256d engine, including async resets
module tb_super_sha256d;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] h1, h2, h3, h4, h5, h6, h7, h8;
  logic [31:0] h1_2, h2_2, h3_2, h4_2, h5_2, h6_2, h7_2, h8_2;
  logic done;
  logic [255:0] cat1, cat2;
  int errors = 0;
  int checks = 0;

  localparam logic [255:0] D1 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D2 = 256'h4f8b42c2_2dd3729b_519ba6f6_8d2da7cc_5b2d606d_05daed5a_d5128cc0_3e6c6358;

  typedef struct {
    int           n;
    logic [255:0] e1;
    logic [255:0] e2;
    logic         ed;
  } vec_t;
  vec_t vecs [5];

  super_sha256d dut (
    .clk(clk), .rst_n(rst_n),
    .h1(h1), .h2(h2), .h3(h3), .h4(h4), .h5(h5), .h6(h6), .h7(h7), .h8(h8),
    .h1_2(h1_2), .h2_2(h2_2), .h3_2(h3_2), .h4_2(h4_2),
    .h5_2(h5_2), .h6_2(h6_2), .h7_2(h7_2), .h8_2(h8_2),
    .done(done)
  );

  always #5 clk = ~clk;
  assign cat1 = {h1, h2, h3, h4, h5, h6, h7, h8};
  assign cat2 = {h1_2, h2_2, h3_2, h4_2, h5_2, h6_2, h7_2, h8_2};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [255:0] e1, input logic [255:0] e2, input logic ed);
    chk({name, "_h"}, cat1, e1);
    chk({name, "_h2"}, cat2, e2);
    chk({name, "_done"}, {255'b0, done}, {255'b0, ed});
  endtask

  // caller releases reset on a falling edge; next rising edge is edge 1
  task automatic run_seq(input string tag);
    for (int n = 1; n <= 132; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++)
        if (vecs[i].n == n) chk_all($sformatf("%s_e%0d", tag, n), vecs[i].e1, vecs[i].e2, vecs[i].ed);
    end
  endtask

  initial begin
    logic [512:0] snap;
    logic changed;
    vecs[0] = '{n: 1,   e1: '0, e2: '0, ed: 1'b0};
    vecs[1] = '{n: 65,  e1: '0, e2: '0, ed: 1'b0};
    vecs[2] = '{n: 66,  e1: D1, e2: '0, ed: 1'b0};
    vecs[3] = '{n: 131, e1: D1, e2: '0, ed: 1'b0};
    vecs[4] = '{n: 132, e1: D1, e2: D2, ed: 1'b1};

    repeat (10) @(posedge clk);
    #1 chk_all("reset_idle", '0, '0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    run_seq("run1");

    snap = {cat1, cat2, done};
    changed = 1'b0;
    repeat (500) begin
      @(posedge clk);
      #1 if ({cat1, cat2, done} !== snap) changed = 1'b1;
    end
    chk("hold_stable", {255'b0, changed}, '0);
    chk_all("hold_end", D1, D2, 1'b1);

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (98) @(posedge clk);
    #1 chk("pre_midreset_h", cat1, D1);
    #2 rst_n = 1'b0;
    #1 chk_all("midrun_async", '0, '0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    run_seq("run2");

    #2 rst_n = 1'b0;
    #1 chk_all("done_async", '0, '0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    run_seq("run3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
